// File: rtl/riscv_cmd_pkg.sv
// Shared opcode, format and decoded-field definitions for the RV32I command decoder.
package riscv_cmd_pkg;

    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    localparam logic [31:0] EBREAK_WORD = 32'h00100073;

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_R    = 3'd1,
        FMT_I    = 3'd2,
        FMT_S    = 3'd3,
        FMT_B    = 3'd4,
        FMT_U    = 3'd5,
        FMT_J    = 3'd6
    } fmt_e;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        fmt_e        fmt;
        logic        illegal;
        logic        ebreak;
    } dec_t;

endpackage

// File: rtl/riscv_command_decoder_fifo.sv
// Parameterised synchronous FIFO holding raw command words ahead of the decoder.
module cmd_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_en, pop_en;

    assign full     = (count_q == FULL_COUNT);
    assign empty    = (count_q == '0);
    assign push_en  = push && !full;
    assign pop_en   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_en)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= push_data;
    end

    // NOTE: non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/riscv_command_decoder.sv
// RV32I command decoder: buffers raw words, decodes the FIFO head into a registered output, halts after EBREAK.
// Optional stat_cmds/stat_illegal counters are built when CMD_DECODER_STATS_EN is defined.
module riscv_command_decoder
    import riscv_cmd_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [XLEN-1:0] cmd_data,
    output logic            dec_valid,
    input  logic            dec_ready,
    output logic [6:0]      dec_opcode,
    output logic [4:0]      dec_rd,
    output logic [4:0]      dec_rs1,
    output logic [4:0]      dec_rs2,
    output logic [2:0]      dec_funct3,
    output logic [6:0]      dec_funct7,
    output logic [XLEN-1:0] dec_imm,
    output logic [2:0]      dec_fmt,
    output logic            dec_illegal,
`ifdef CMD_DECODER_STATS_EN
    output logic [31:0]     stat_cmds,
    output logic [15:0]     stat_illegal,
`endif
    output logic            halted
);

    state_e          state_q, state_d;
    dec_t            dec_q, dec_d, head_dec;
    logic            dec_valid_q, dec_valid_d;
    logic [XLEN-1:0] head_word;
    logic            fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic            consume, load;

    assign cmd_ready = (state_q == RUN) && !fifo_full;
    assign fifo_push = cmd_valid && cmd_ready && !reset;
    assign consume   = dec_valid_q && dec_ready;
    assign load      = (!dec_valid_q || dec_ready) && !fifo_empty && (state_q != HALTED);
    assign fifo_pop  = load;

    cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (XLEN)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (cmd_data),
        .pop       (fifo_pop),
        .pop_data  (head_word),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        head_dec        = '0;
        head_dec.opcode = head_word[6:0];
        head_dec.rd     = head_word[11:7];
        head_dec.funct3 = head_word[14:12];
        head_dec.rs1    = head_word[19:15];
        head_dec.rs2    = head_word[24:20];
        head_dec.funct7 = head_word[31:25];
        head_dec.fmt    = FMT_NONE;
        head_dec.ebreak = (head_word == EBREAK_WORD);
        case (head_word[6:0])
            OP_OP: head_dec.fmt = FMT_R;
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM, OP_FENCE: begin
                head_dec.fmt = FMT_I;
                head_dec.imm = {{20{head_word[31]}}, head_word[31:20]};
            end
            OP_STORE: begin
                head_dec.fmt = FMT_S;
                head_dec.imm = {{20{head_word[31]}}, head_word[31:25], head_word[11:7]};
            end
            OP_BRANCH: begin
                head_dec.fmt = FMT_B;
                head_dec.imm = {{20{head_word[31]}}, head_word[7], head_word[30:25],
                                head_word[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                head_dec.fmt = FMT_U;
                head_dec.imm = {head_word[31:12], 12'b0};
            end
            OP_JAL: begin
                head_dec.fmt = FMT_J;
                head_dec.imm = {{12{head_word[31]}}, head_word[19:12], head_word[20],
                                head_word[30:21], 1'b0};
            end
            default: head_dec.illegal = 1'b1;
        endcase
    end

    always_comb begin
        dec_d       = dec_q;
        dec_valid_d = dec_valid_q;
        state_d     = state_q;
        if (load) begin
            dec_d       = head_dec;
            dec_valid_d = 1'b1;
        end else if (consume) begin
            dec_valid_d = 1'b0;
        end
        case (state_q)
            RUN:     if (fifo_push && (cmd_data == EBREAK_WORD)) state_d = DRAIN;
            DRAIN:   if (consume && dec_q.ebreak) state_d = HALTED;
            HALTED:  state_d = HALTED;
            default: state_d = RUN;
        endcase
        // The EBREAK consume also empties the output stage; nothing follows it.
        if (state_d == HALTED) dec_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RUN;
            dec_q       <= '0;
            dec_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dec_q       <= dec_d;
            dec_valid_q <= dec_valid_d;
        end
    end

    assign dec_valid   = dec_valid_q;
    assign dec_opcode  = dec_q.opcode;
    assign dec_rd      = dec_q.rd;
    assign dec_rs1     = dec_q.rs1;
    assign dec_rs2     = dec_q.rs2;
    assign dec_funct3  = dec_q.funct3;
    assign dec_funct7  = dec_q.funct7;
    assign dec_imm     = dec_q.imm;
    assign dec_fmt     = dec_q.fmt;
    assign dec_illegal = dec_q.illegal;
    assign halted      = (state_q == HALTED);

`ifdef CMD_DECODER_STATS_EN
    logic [31:0] stat_cmds_q, stat_cmds_d;
    logic [15:0] stat_illegal_q, stat_illegal_d;

    always_comb begin
        stat_cmds_d    = stat_cmds_q;
        stat_illegal_d = stat_illegal_q;
        if (consume) begin
            stat_cmds_d = stat_cmds_q + 32'd1;
            if (dec_q.illegal) stat_illegal_d = stat_illegal_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_cmds_q    <= '0;
            stat_illegal_q <= '0;
        end else begin
            stat_cmds_q    <= stat_cmds_d;
            stat_illegal_q <= stat_illegal_d;
        end
    end

    assign stat_cmds    = stat_cmds_q;
    assign stat_illegal = stat_illegal_q;
`endif

endmodule
